// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse tracker and its consumers.
// Holds the packet assembler state encoding, the header bit positions of a
// standard 3-byte PS/2 mouse packet, the default clamp/init constants that the
// gun logic also relies on, and the packet structs passed between the
// assembler and the position accumulator.
package mouse_pkg;

    // Packet assembler states: which byte of the packet is expected next.
    typedef logic [1:0] state_t;
    localparam state_t S_B0 = 2'd0;
    localparam state_t S_B1 = 2'd1;
    localparam state_t S_B2 = 2'd2;

    // Header (byte0) bit positions.
    localparam int HDR_L    = 0;
    localparam int HDR_R    = 1;
    localparam int HDR_SYNC = 3;
    localparam int HDR_XS   = 4;
    localparam int HDR_YS   = 5;
    localparam int HDR_XO   = 6;
    localparam int HDR_YO   = 7;

    // Default geometry shared with the gun.
    localparam int DEF_BIN_W         = 6;
    localparam int DEF_BIN_SIZE      = 10;
    localparam int DEF_X_MIN         = 0;
    localparam int DEF_X_MAX         = 570;
    localparam int DEF_Y_MIN         = 70;
    localparam int DEF_Y_MAX         = 480;
    localparam int DEF_X_INIT        = 320;
    localparam int DEF_Y_INIT        = 240;
    localparam int DEF_TIMEOUT_TICKS = 100_000;

    // Header fields the accumulator needs.
    typedef struct packed {
        logic yo;
        logic xo;
        logic ys;
        logic xs;
        logic r;
        logic l;
    } hdr_t;

    // One complete packet as handed to the accumulator.
    typedef struct packed {
        hdr_t       hdr;
        logic [7:0] dx;
        logic [7:0] dy;
    } pkt_t;

endpackage

// File: rtl/mouse_tracker_if.sv
// Byte stream from the PS/2 byte receiver into the mouse tracker.
//   byte_data  : received PS/2 byte
//   byte_valid : 1-cycle strobe, byte_data is valid
//   byte_err   : 1-cycle strobe, parity/frame error on the current byte
// master = byte receiver side, slave = mouse tracker side.
interface mouse_tracker_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_err;

    modport master (output byte_data, output byte_valid, output byte_err);
    modport slave  (input  byte_data, input  byte_valid, input  byte_err);
endinterface

// File: rtl/ps2_pkt_assembler.sv
// Assembles 3-byte PS/2 mouse packets from the received byte stream.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : byte stream (slave side)
//   pkt_o        : 1-cycle strobe in the cycle byte2 is accepted
//   pkt_data_o   : header fields, dx byte and dy byte (dy is the live byte2)
//   sync_err_o   : 1-cycle pulse, registered, when a packet is discarded
// A partial packet is discarded on a bad sync bit, a byte error, or when the
// gap between bytes of one packet reaches TIMEOUT_TICKS cycles.
module ps2_pkt_assembler
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic            clk,
    input  logic            reset_n,
    mouse_tracker_if.slave  bus,
    output logic            pkt_o,
    output pkt_t            pkt_data_o,
    output logic            sync_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hdr_t             hdr_q, hdr_d;
    logic [7:0]       dx_q, dx_d;
    logic             sync_err_q, sync_err_d;
    logic             timeout;
    state_t           cur_state;
    logic             pkt;

    always_comb begin
        timeout    = (state_q != S_B0) && (cnt_q == CNT_LAST);
        // A byte arriving in the timeout cycle starts a fresh packet.
        cur_state  = timeout ? S_B0 : state_q;
        state_d    = state_q;
        cnt_d      = (state_q == S_B0) ? '0 : cnt_q + CNT_W'(1);
        hdr_d      = hdr_q;
        dx_d       = dx_q;
        sync_err_d = 1'b0;
        pkt        = 1'b0;

        if (bus.byte_err) begin
            // Error wins over a simultaneous byte_valid.
            state_d    = S_B0;
            cnt_d      = '0;
            sync_err_d = 1'b1;
        end else begin
            if (timeout) begin
                state_d    = S_B0;
                cnt_d      = '0;
                sync_err_d = 1'b1;
            end
            if (bus.byte_valid) begin
                cnt_d = '0;
                case (cur_state)
                    S_B0: begin
                        if (bus.byte_data[HDR_SYNC]) begin
                            hdr_d.l  = bus.byte_data[HDR_L];
                            hdr_d.r  = bus.byte_data[HDR_R];
                            hdr_d.xs = bus.byte_data[HDR_XS];
                            hdr_d.ys = bus.byte_data[HDR_YS];
                            hdr_d.xo = bus.byte_data[HDR_XO];
                            hdr_d.yo = bus.byte_data[HDR_YO];
                            state_d  = S_B1;
                        end else begin
                            state_d    = S_B0;
                            sync_err_d = 1'b1;
                        end
                    end
                    S_B1: begin
                        dx_d    = bus.byte_data;
                        state_d = S_B2;
                    end
                    S_B2: begin
                        pkt     = 1'b1;
                        state_d = S_B0;
                    end
                    default: state_d = S_B0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_B0;
            cnt_q      <= '0;
            hdr_q      <= '0;
            dx_q       <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            dx_q       <= dx_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign pkt_o      = pkt;
    assign pkt_data_o = '{hdr: hdr_q, dx: dx_q, dy: bus.byte_data};
    assign sync_err_o = sync_err_q;

endmodule

// File: rtl/mouse_tracker.sv
// PS/2 mouse packet decoder and position accumulator feeding the gun.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus            : byte stream from the PS/2 byte receiver (slave side)
//   bin_x, bin_y   : clamped pixel position divided by BIN_SIZE
//   button_left/right : button states from the packet header
//   pkt_valid      : 1-cycle pulse, outputs just updated from a new packet
//   sync_err       : 1-cycle pulse, packet discarded
// Byte2 accepted in cycle T: position updates at T+1, all outputs at T+2.
module mouse_tracker
    import mouse_pkg::*;
#(
    parameter int BIN_W         = DEF_BIN_W,
    parameter int BIN_SIZE      = DEF_BIN_SIZE,
    parameter int X_MIN         = DEF_X_MIN,
    parameter int X_MAX         = DEF_X_MAX,
    parameter int Y_MIN         = DEF_Y_MIN,
    parameter int Y_MAX         = DEF_Y_MAX,
    parameter int X_INIT        = DEF_X_INIT,
    parameter int Y_INIT        = DEF_Y_INIT,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic             clk,
    input  logic             reset_n,
    mouse_tracker_if.slave   bus,
    output logic [BIN_W-1:0] bin_x,
    output logic [BIN_W-1:0] bin_y,
    output logic             button_left,
    output logic             button_right,
    output logic             pkt_valid,
    output logic             sync_err
);

    localparam logic signed [11:0] X_MIN_S  = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S  = 12'(X_MAX);
    localparam logic signed [11:0] Y_MIN_S  = 12'(Y_MIN);
    localparam logic signed [11:0] Y_MAX_S  = 12'(Y_MAX);
    localparam logic signed [11:0] X_INIT_S = 12'(X_INIT);
    localparam logic signed [11:0] Y_INIT_S = 12'(Y_INIT);

    function automatic logic signed [11:0] clamp(input logic signed [11:0] v,
                                                 input logic signed [11:0] lo,
                                                 input logic signed [11:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [BIN_W-1:0] to_bin(input logic signed [11:0] p);
        int q;
        q = int'(p) / BIN_SIZE;
        return BIN_W'(q);
    endfunction

    pkt_t pkt;
    logic pkt_stb;

    ps2_pkt_assembler #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_asm (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .pkt_o      (pkt_stb),
        .pkt_data_o (pkt),
        .sync_err_o (sync_err)
    );

    logic signed [8:0]  dx_p0, dy_p0;
    logic signed [11:0] pos_x_d, pos_y_d;
    logic signed [11:0] pos_x_q, pos_y_q;
    logic               btn_l_p1_q, btn_r_p1_q, vld_p1_q;
    logic [BIN_W-1:0]   bin_x_q, bin_y_q;
    logic               btn_l_q, btn_r_q, pkt_valid_q;

    // Stage p0: decode deltas and accumulate with saturation.
    always_comb begin
        dx_p0   = pkt.hdr.xo ? 9'sd0 : $signed({pkt.hdr.xs, pkt.dx});
        dy_p0   = pkt.hdr.yo ? 9'sd0 : $signed({pkt.hdr.ys, pkt.dy});
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (pkt_stb) begin
            // 12-bit signed sum cannot wrap: |pos| < 1024, |delta| <= 256.
            pos_x_d = clamp(pos_x_q + 12'(dx_p0), X_MIN_S, X_MAX_S);
            pos_y_d = clamp(pos_y_q + 12'(dy_p0), Y_MIN_S, Y_MAX_S);
        end
    end

    // Stage p1: position and button registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q    <= X_INIT_S;
            pos_y_q    <= Y_INIT_S;
            btn_l_p1_q <= 1'b0;
            btn_r_p1_q <= 1'b0;
            vld_p1_q   <= 1'b0;
        end else begin
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            vld_p1_q <= pkt_stb;
            if (pkt_stb) begin
                btn_l_p1_q <= pkt.hdr.l;
                btn_r_p1_q <= pkt.hdr.r;
            end
        end
    end

    // Stage p2: bin divide; buttons delayed to line up with the bins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_x_q     <= to_bin(X_INIT_S);
            bin_y_q     <= to_bin(Y_INIT_S);
            btn_l_q     <= 1'b0;
            btn_r_q     <= 1'b0;
            pkt_valid_q <= 1'b0;
        end else begin
            bin_x_q     <= to_bin(pos_x_q);
            bin_y_q     <= to_bin(pos_y_q);
            btn_l_q     <= btn_l_p1_q;
            btn_r_q     <= btn_r_p1_q;
            pkt_valid_q <= vld_p1_q;
        end
    end

    assign bin_x        = bin_x_q;
    assign bin_y        = bin_y_q;
    assign button_left  = btn_l_q;
    assign button_right = btn_r_q;
    assign pkt_valid    = pkt_valid_q;

endmodule
